// File: rtl/pwm_audio_out_pkg.sv
// Shared defaults for the PWM audio output stage: widths, gain headroom and PWM full-scale helper.
package pwm_audio_out_pkg;

    localparam int DEF_IN_W      = 16;
    localparam int DEF_PWM_W     = 10;
    localparam int DEF_FIFO_LOG2 = 2;

    // Extra bits above the sample so a 0..15 left shift never loses the saturation condition.
    localparam int GAIN_HEADROOM = 15;

    function automatic int pwm_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for audio samples; a push into a full FIFO is accepted when a pop frees a slot.
module sample_fifo #(
    parameter int W    = 16,
    parameter int LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << LOG2;
    localparam logic [LOG2:0] FULL_LVL = {1'b1, {LOG2{1'b0}}};

    logic [W-1:0]    mem [DEPTH];
    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic [LOG2:0]   level;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: sample FIFO, power-of-two gain with saturation, duty update once per PWM period.
// Optional first-order dither of the truncated residual when PWM_DITHER_EN is defined.
module pwm_audio_out
    import pwm_audio_out_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int PWM_W     = DEF_PWM_W,
    parameter int FIFO_LOG2 = DEF_FIFO_LOG2
) (
    input  logic            clk,
    input  logic            RST,
    input  logic [IN_W-1:0] in_sample,
    input  logic            in_tick,
    input  logic [3:0]      gain_shift,
    output logic            pwm_out,
    output logic            period_tick,
    output logic            fifo_full,
    output logic            overflow,
    output logic            underrun
);

    localparam int RES_W = IN_W - PWM_W;
    localparam logic [PWM_W-1:0] PWM_MAX = PWM_W'(pwm_max(PWM_W));

    logic [PWM_W-1:0]              count;
    logic [PWM_W-1:0]              duty;
    logic [PWM_W-1:0]              duty_next;
    logic [PWM_W-1:0]              quant;
    logic [IN_W-1:0]               head;
    logic [IN_W+GAIN_HEADROOM-1:0] s_wide;
    logic [IN_W-1:0]               s_sat;
    logic                          fifo_empty;
    logic                          wrap;
    logic                          pop;

    assign wrap = (count == PWM_MAX);
    assign pop  = wrap && !fifo_empty;

    sample_fifo #(
        .W    (IN_W),
        .LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (RST),
        .push  (in_tick),
        .pop   (pop),
        .din   (in_sample),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Gain is applied at pop time, so the shift in force at the period boundary is the one used.
    assign s_wide = {{GAIN_HEADROOM{1'b0}}, head} << gain_shift;
    assign s_sat  = (|s_wide[IN_W+GAIN_HEADROOM-1:IN_W]) ? '1 : s_wide[IN_W-1:0];
    assign quant  = s_sat[IN_W-1 -: PWM_W];

`ifdef PWM_DITHER_EN
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_next;
    logic             carry;

    assign {carry, acc_next} = {1'b0, acc} + {1'b0, s_sat[RES_W-1:0]};
    assign duty_next = (carry && quant != PWM_MAX) ? quant + 1'b1 : quant;

    always_ff @(posedge clk) begin
        if (RST)      acc <= '0;
        else if (pop) acc <= acc_next;
    end
`else
    logic unused_residual;

    assign unused_residual = ^s_sat[RES_W-1:0];
    assign duty_next       = quant;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            count       <= '0;
            duty        <= '0;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            count       <= count + 1'b1;
            period_tick <= wrap;
            underrun    <= wrap && fifo_empty;
            pwm_out     <= (count < duty);
            if (pop) duty <= duty_next;
            if (in_tick && fifo_full && !pop) overflow <= 1'b1;
        end
    end

endmodule
